spi_peripheral_frontend: RTL and testbench
==========================================

// Module: spi_peripheral_frontend
// PURPOSE
//  Parametrised SPI peripheral datapath: conditions raw SCLK/CS_N/MOSI pins, shifts WIDTH-bit frames in and out.
//  Successor to the fixed 8-bit shift-register + per-pin conditioner test harness.
//  Adds chip-select framing, bit counting, a received-word handshake and SCLK polarity selection.
//  Sits between the board pins and the register-file/control logic.
// PARAMETERS
//  WIDTH            8   frame length in bits (>=2)
//  SYNC_STAGES      2   synchroniser flops per raw input (>=2)
//  DEBOUNCE_CYCLES  3   consecutive stable clk cycles needed before a conditioned level changes (>=1)
//  CPOL             0   SCLK idle level; mode is always CPHA=0
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  reset         in   1      synchronous, active-high
//  sclk_raw      in   1      unsynchronised SPI clock pin
//  cs_n_raw      in   1      unsynchronised chip select, active low
//  mosi_raw      in   1      unsynchronised serial data in
//  load_req      in   1      pulse: load load_data into the tx shift register
//  load_data     in   WIDTH  word for the next frame
//  load_drop     out  1      1-cycle pulse: load_req was ignored (not IDLE)
//  miso          out  1      shift_reg[WIDTH-1], MSB first
//  rx_data       out  WIDTH  last complete received frame
//  rx_valid      out  1      1-cycle pulse when rx_data updates
//  busy          out  1      high in ACTIVE
//  frame_count   out  16     completed frames, wraps (only with SPI_FRAME_CNT_EN)
// BEHAVIOUR
//  Conditioners:
//   - Chain: SYNC_STAGES flops -> stability counter.
//   - Conditioned level takes the synced value once it has differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
//   - Any glitch shorter than that restarts the count.
//   - rise/fall pulses are 1 cycle, in the cycle the level changes.
//   - Latency from a stable raw change to its edge pulse: SYNC_STAGES + DEBOUNCE_CYCLES cycles.
//  Edges: lead = SCLK rise if CPOL=0, else fall; trail = the opposite edge.
//  FSM IDLE:
//   - Entered on reset and whenever cs_n is conditioned high.
//   - busy=0, bit_cnt=0; SCLK edges are ignored.
//   - load_req: shift_reg <= load_data.
//   - cs_n fall -> ACTIVE.
//  FSM ACTIVE:
//   - lead: mosi_bit <= conditioned mosi; bit_cnt++.
//   - trail: shift_reg <= {shift_reg[WIDTH-2:0], mosi_bit}.
//   - On the lead edge where bit_cnt==WIDTH-1:
//     - next cycle rx_data <= {shift_reg[WIDTH-2:0], mosi_conditioned}, rx_valid=1 for 1 cycle;
//     - bit_cnt wraps to 0 and the FSM stays ACTIVE (back-to-back frames).
//     - After the following trail edge shift_reg holds the received word, so the next frame echoes it unless reloaded in IDLE.
//   - load_req here is ignored; load_drop pulses the following cycle.
//  cs_n rise mid-frame (bit_cnt!=0):
//   - abort, no rx_valid, bit_cnt <= 0, -> IDLE.
//   - shift_reg keeps its partial contents.
//  Simultaneous cs_n rise and lead edge in one cycle: the cs_n rise wins and the edge is discarded.
//  Simultaneous load_req and cs_n fall: the load is accepted (still IDLE that cycle).
//  Reset values:
//   - shift_reg, rx_data, rx_valid, load_drop, busy, miso, bit_cnt, frame_count = 0.
//   - Conditioned cs_n = 1, sclk = CPOL, mosi = 0; no edge pulses are generated on reset release.
//  Reset mid-frame: same as abort, with all state at reset values.
// CONFIGURATION
//  SPI_FRAME_CNT_EN defined:
//   - frame_count port exists and increments with each rx_valid, wrapping 0xFFFF->0.
//  SPI_FRAME_CNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  Package spi_pkg: FSM state localparams (ST_IDLE, ST_ACTIVE), FRAME_CNT_W=16, default WIDTH/SYNC/DEBOUNCE.
//  Sub-module spi_input_conditioner (SYNC_STAGES, DEBOUNCE_CYCLES, RESET_LEVEL):
//   - outputs conditioned, rise, fall;
//   - instantiated once per pin.
//  Top holds the FSM, bit counter, shift register and rx register.
// TESTING (defaults, clk-synchronous SPI model, SCLK half-period >= 8 clk)
//  - load 0xA5 in IDLE, cs_n low, 8 SCLK with MOSI=0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C, one rx_valid pulse.
//  - 2-cycle glitch on sclk_raw mid-frame -> no bit_cnt change, frame still yields the correct rx_data.
//  - cs_n high after 5 bits -> no rx_valid, busy=0; next full frame 0x81 -> rx_data=0x81.
//  - two frames under one cs_n, second without reload -> first rx 0x12, miso echoes 0x12, second rx 0x34; two rx_valid pulses.
//  - load_req while busy -> load_drop pulse, shift_reg unchanged.
//  - reset asserted at bit 4, then CPOL=1 build full frame -> all outputs 0; post-reset frame correct.
//    With SPI_FRAME_CNT_EN, 3 frames -> frame_count=3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI peripheral front end.
// Contents: FSM state encodings, frame counter width, default parameter values.
// The frame counter width is only used when SPI_FRAME_CNT_EN is defined.
package spi_pkg;

    localparam int unsigned DEF_WIDTH           = 8;
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 3;
    localparam int unsigned FRAME_CNT_W         = 16;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/spi_input_conditioner.sv
// Per-pin conditioner: synchroniser chain followed by a stability counter.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   raw          asynchronous pin input
//   conditioned  debounced level (RESET_LEVEL out of reset)
//   rise, fall   1-cycle pulses, asserted in the cycle the level changes
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic conditioned,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       stable_cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Level follows the synced input only after DEBOUNCE_CYCLES consecutive
    // differing samples; any return to the current level restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= {SYNC_STAGES{RESET_LEVEL}};
            stable_cnt_q <= '0;
            conditioned  <= RESET_LEVEL;
            rise         <= 1'b0;
            fall         <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (synced == conditioned) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q == CNT_LAST) begin
                conditioned  <= synced;
                rise         <= synced;
                fall         <= ~synced;
                stable_cnt_q <= '0;
            end else begin
                stable_cnt_q <= stable_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_peripheral_frontend.sv
// SPI peripheral datapath (CPHA=0): conditions SCLK/CS_N/MOSI, shifts WIDTH-bit
// frames in and out, and hands received words to the register file.
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   sclk_raw/cs_n_raw/mosi_raw  unsynchronised pins
//   load_req, load_data     load next tx word (accepted only in IDLE)
//   load_drop               1-cycle pulse when load_req was ignored
//   miso                    MSB of the shift register
//   rx_data, rx_valid       last complete frame and its 1-cycle strobe
//   busy                    high while a cs_n-framed transfer is active
//   frame_count             completed frames, present only with SPI_FRAME_CNT_EN
// Build option: define SPI_FRAME_CNT_EN to add the 16-bit frame counter port.
module spi_peripheral_frontend
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH           = DEF_WIDTH,
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic        CPOL            = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_raw,
    input  logic             cs_n_raw,
    input  logic             mosi_raw,
    input  logic             load_req,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_drop,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy
`ifdef SPI_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic sclk_c, sclk_rise, sclk_fall;
    logic cs_n_c, cs_n_rise, cs_n_fall;
    logic mosi_c, mosi_rise, mosi_fall;
    logic lead, trail;
    logic unused_pins;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             mosi_bit_q, mosi_bit_d;
    logic [WIDTH-1:0] rx_data_d;
    logic             rx_valid_d, load_drop_d;

    spi_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(CPOL)
    ) u_sclk (
        .clk(clk), .reset(reset), .raw(sclk_raw),
        .conditioned(sclk_c), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)
    ) u_cs_n (
        .clk(clk), .reset(reset), .raw(cs_n_raw),
        .conditioned(cs_n_c), .rise(cs_n_rise), .fall(cs_n_fall)
    );

    spi_input_conditioner #(
        .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)
    ) u_mosi (
        .clk(clk), .reset(reset), .raw(mosi_raw),
        .conditioned(mosi_c), .rise(mosi_rise), .fall(mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi drive the datapath.
    assign unused_pins = &{1'b0, sclk_c, cs_n_c, mosi_rise, mosi_fall};

    assign lead  = CPOL ? sclk_fall : sclk_rise;
    assign trail = CPOL ? sclk_rise : sclk_fall;
    assign miso  = shift_q[WIDTH-1];

    // Next-state and datapath decode; a cs_n rise overrides any same-cycle SCLK edge.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mosi_bit_d  = mosi_bit_q;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        load_drop_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (load_req) shift_d = load_data;
                if (cs_n_fall) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (load_req) load_drop_d = 1'b1;
                if (cs_n_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                end else begin
                    if (lead) begin
                        mosi_bit_d = mosi_c;
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d  = '0;
                            rx_data_d  = {shift_q[WIDTH-2:0], mosi_c};
                            rx_valid_d = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (trail) shift_d = {shift_q[WIDTH-2:0], mosi_bit_q};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            mosi_bit_q <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            load_drop  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mosi_bit_q <= mosi_bit_d;
            rx_data    <= rx_data_d;
            rx_valid   <= rx_valid_d;
            load_drop  <= load_drop_d;
            busy       <= (state_d == ST_ACTIVE);
        end
    end

`ifdef SPI_FRAME_CNT_EN
    // Completed-frame counter, wraps naturally at 2^FRAME_CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
        end else if (rx_valid_d) begin
            frame_count <= frame_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_peripheral_frontend.sv
// Bench for spi_peripheral_frontend: a CPOL=0 instance and a CPOL=1 instance
// driven with complementary SCLK, so both must behave identically.
module tb_spi_peripheral_frontend;

    localparam int HALF = 8;

    typedef struct {
        logic       reload;
        logic [7:0] load_word;
        logic [7:0] mosi_word;
        int         nbits;
        logic       keep_cs;
        logic       glitch;
        logic       load_busy;
        logic [7:0] exp_miso;
    } frame_vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0;
    logic sclk_inv;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic load_req = 1'b0;
    logic [7:0] load_data = '0;

    logic       load_drop0, miso0, rx_valid0, busy0;
    logic       load_drop1, miso1, rx_valid1, busy1;
    logic [7:0] rx_data0, rx_data1;
`ifdef SPI_FRAME_CNT_EN
    logic [15:0] frame_count0, frame_count1;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_frames = 0;
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    frame_vec_t vecs[11];

    assign sclk_inv = ~sclk;

    always #5 clk = ~clk;

    spi_peripheral_frontend #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .CPOL(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .sclk_raw(sclk), .cs_n_raw(cs_n), .mosi_raw(mosi),
        .load_req(load_req), .load_data(load_data), .load_drop(load_drop0),
        .miso(miso0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0)
`ifdef SPI_FRAME_CNT_EN
        , .frame_count(frame_count0)
`endif
    );

    spi_peripheral_frontend #(
        .WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .CPOL(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .sclk_raw(sclk_inv), .cs_n_raw(cs_n), .mosi_raw(mosi),
        .load_req(load_req), .load_data(load_data), .load_drop(load_drop1),
        .miso(miso1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
`ifdef SPI_FRAME_CNT_EN
        , .frame_count(frame_count1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every rx_valid pulse must match the oldest pending frame.
    always @(negedge clk) begin
        if (rx_valid0) begin
            check("rx_pending0", 32'(exp_q0.size() != 0), 32'd1);
            if (exp_q0.size() != 0) check("rx_data0", 32'(rx_data0), 32'(exp_q0.pop_front()));
        end
        if (rx_valid1) begin
            check("rx_pending1", 32'(exp_q1.size() != 0), 32'd1);
            if (exp_q1.size() != 0) check("rx_data1", 32'(rx_data1), 32'(exp_q1.pop_front()));
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy0"}, 32'(busy0), 32'd0);
        check({tag, "_busy1"}, 32'(busy1), 32'd0);
        check({tag, "_rx_data0"}, 32'(rx_data0), 32'd0);
        check({tag, "_rx_data1"}, 32'(rx_data1), 32'd0);
        check({tag, "_rx_valid"}, 32'({rx_valid0, rx_valid1}), 32'd0);
        check({tag, "_load_drop"}, 32'({load_drop0, load_drop1}), 32'd0);
        check({tag, "_miso"}, 32'({miso0, miso1}), 32'd0);
`ifdef SPI_FRAME_CNT_EN
        check({tag, "_frame_count0"}, 32'(frame_count0), 32'd0);
        check({tag, "_frame_count1"}, 32'(frame_count1), 32'd0);
`endif
    endtask

    task automatic apply_vec(input int idx, input frame_vec_t v);
        logic [7:0] mw0;
        logic [7:0] mw1;
        mw0 = '0;
        mw1 = '0;
        if (v.reload) begin
            load_req  = 1'b1;
            load_data = v.load_word;
            tick(1);
            load_req  = 1'b0;
            load_data = '0;
        end
        if (cs_n) begin
            cs_n = 1'b0;
            tick(HALF);
        end
        @(negedge clk);
        check($sformatf("v%0d_busy0", idx), 32'(busy0), 32'd1);
        check($sformatf("v%0d_busy1", idx), 32'(busy1), 32'd1);
        tick(1);
        if (v.load_busy) begin
            load_req  = 1'b1;
            load_data = ~v.load_word;
            tick(1);
            load_req  = 1'b0;
            load_data = '0;
            @(negedge clk);
            check($sformatf("v%0d_load_drop", idx), 32'({load_drop0, load_drop1}), 32'h3);
            @(negedge clk);
            check($sformatf("v%0d_load_drop_end", idx), 32'({load_drop0, load_drop1}), 32'h0);
            tick(1);
        end
        for (int b = 0; b < v.nbits; b++) begin
            mosi = v.mosi_word[7-b];
            tick(HALF);
            @(negedge clk);
            mw0 = {mw0[6:0], miso0};
            mw1 = {mw1[6:0], miso1};
            if (b == 7) begin
                exp_q0.push_back(v.mosi_word);
                exp_q1.push_back(v.mosi_word);
                exp_frames++;
            end
            tick(1);
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
            if (v.glitch && b == 3) begin
                tick(HALF / 2);
                sclk = 1'b1;
                tick(2);
                sclk = 1'b0;
            end
        end
        tick(HALF);
        check($sformatf("v%0d_miso0", idx), 32'(mw0), 32'(v.exp_miso));
        check($sformatf("v%0d_miso1", idx), 32'(mw1), 32'(v.exp_miso));
        if (!v.keep_cs) begin
            cs_n = 1'b1;
            tick(HALF);
            @(negedge clk);
            check($sformatf("v%0d_idle_busy", idx), 32'({busy0, busy1}), 32'h0);
            tick(1);
        end
    endtask

    initial begin
        //          reload load   mosi   nbits keep glitch lbusy exp_miso
        vecs[0]  = '{1'b1, 8'hA5, 8'h3C, 8, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[1]  = '{1'b1, 8'hF0, 8'hFF, 5, 1'b0, 1'b0, 1'b0, 8'h1E};
        vecs[2]  = '{1'b0, 8'h00, 8'h81, 8, 1'b0, 1'b0, 1'b0, 8'h1F};
        vecs[3]  = '{1'b1, 8'hC3, 8'h12, 8, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[4]  = '{1'b0, 8'h00, 8'h34, 8, 1'b0, 1'b0, 1'b0, 8'h12};
        vecs[5]  = '{1'b1, 8'h69, 8'h96, 8, 1'b0, 1'b1, 1'b0, 8'h69};
        vecs[6]  = '{1'b1, 8'hFF, 8'h00, 8, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[7]  = '{1'b1, 8'h00, 8'hFF, 8, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[8]  = '{1'b0, 8'h00, 8'hA7, 8, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b0, 8'h00, 8'h5E, 8, 1'b0, 1'b0, 1'b0, 8'hA7};
        vecs[10] = '{1'b1, 8'h81, 8'h42, 8, 1'b0, 1'b0, 1'b0, 8'h81};

        tick(4);
        @(negedge clk);
        check_all_zero("in_reset");
        tick(4);
        reset = 1'b0;
        tick(HALF);
        @(negedge clk);
        check_all_zero("post_reset");
        tick(1);

        for (int i = 0; i < 8; i++) apply_vec(i, vecs[i]);

        // Partial frame interrupted by reset at bit 4.
        apply_vec(100, '{1'b1, 8'h55, 8'hC0, 4, 1'b1, 1'b0, 1'b0, 8'h05});
        reset = 1'b1;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        tick(3);
        @(negedge clk);
        check_all_zero("mid_frame_reset");
        tick(6);
        reset = 1'b0;
        exp_frames = 0;
        tick(HALF);
        @(negedge clk);
        check_all_zero("after_mid_reset");
        tick(1);

        for (int i = 8; i < 11; i++) apply_vec(i, vecs[i]);

        tick(2 * HALF);
`ifdef SPI_FRAME_CNT_EN
        check("frame_count0", 32'(frame_count0), 32'(exp_frames));
        check("frame_count1", 32'(frame_count1), 32'(exp_frames));
`endif
        check("rx_leftover0", 32'(exp_q0.size()), 32'd0);
        check("rx_leftover1", 32'(exp_q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
